// File: rtl/adsr_envelope_gen.sv
`default_nettype none
// ============================================================================
// Module      : adsr_envelope_gen
// Description : Multi-mode ADSR envelope generator with prescaled rate
//               counter, legato retrigger, AD-loop mode, explicit retrigger
//               strobe and a one-cycle release-done pulse. All outputs are
//               registered.
// Revision    : 1.0 - initial release
// ============================================================================
module adsr_envelope_gen #(
   parameter int ENV_W      = 12,
   parameter int RATE_W     = 8,
   parameter int PRESCALE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              gate,
   input  logic              retrig,
   input  logic              legato,
   input  logic              loop_en,
   input  logic [RATE_W-1:0] attack_rate,
   input  logic [RATE_W-1:0] decay_rate,
   input  logic [ENV_W-1:0]  sustain_level,
   input  logic [RATE_W-1:0] release_rate,
   output logic [ENV_W-1:0]  envelope_out,
   output logic [2:0]        state_out,
   output logic              active,
   output logic              release_done
);

   localparam int CNT_W = RATE_W + PRESCALE_W;

   localparam logic [ENV_W-1:0] c_ENV_MAX = '1;
   localparam logic [ENV_W-1:0] c_ENV_ONE = {{(ENV_W-1){1'b0}}, 1'b1};
   localparam logic [ENV_W:0]   c_EXT_ONE = {{ENV_W{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;
   logic [ENV_W-1:0]   r_env;
   logic [ENV_W-1:0]   w_env_nx;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_load;
   logic               r_gate_prev;
   logic               r_active;
   logic               r_release_done;
   logic               w_done_nx;
   logic               w_restart;
   logic               w_reload;
   logic               w_tick;
   logic               w_rise;
   logic               w_restart_req;
   logic [RATE_W-1:0]  w_rate;
   logic [RATE_W-1:0]  w_nx_rate;
   logic [ENV_W:0]     w_env_x;
   logic [ENV_W:0]     w_sus_p1;

   // Only the timed states have a rate; IDLE and SUSTAIN run at rate 0.
   function automatic logic [RATE_W-1:0] rate_sel(input state_t s);
      case (s)
         S_ATTACK:  rate_sel = attack_rate;
         S_DECAY:   rate_sel = decay_rate;
         S_RELEASE: rate_sel = release_rate;
         default:   rate_sel = '0;
      endcase
   endfunction

   assign w_rise        = gate & ~r_gate_prev;
   assign w_restart_req = retrig | w_rise;
   assign w_rate        = rate_sel(r_state);
   assign w_nx_rate     = rate_sel(w_state_nx);
   // A rate of 0 means "instant", so it ticks regardless of the counter.
   assign w_tick        = (w_rate == '0) || (r_cnt == '0);
   // Rate 0 loads 0 rather than wrapping, so a later non-zero rate ticks at once.
   assign w_load        = (w_nx_rate == '0) ? '0
                          : ({w_nx_rate, {PRESCALE_W{1'b0}}} - c_CNT_ONE);
   assign w_reload      = (w_state_nx != r_state) || w_restart || w_tick;
   assign w_env_x       = {1'b0, r_env};
   assign w_sus_p1      = {1'b0, sustain_level} + c_EXT_ONE;

   // Next-state / next-envelope decision: gate low > restart > tick.
   always_comb begin
      w_state_nx = r_state;
      w_env_nx   = r_env;
      w_done_nx  = 1'b0;
      w_restart  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_env_nx = '0;
            if (gate) w_state_nx = S_ATTACK;
         end
         S_ATTACK: begin
            if (!gate) begin
               w_state_nx = S_RELEASE;
            end else if (w_restart_req) begin
               w_restart = 1'b1;
               w_env_nx  = legato ? r_env : '0;
            end else if (w_tick) begin
               // Saturate at full scale and hand over to decay in one update.
               if ((w_rate == '0) || (r_env >= c_ENV_MAX - c_ENV_ONE)) begin
                  w_env_nx   = c_ENV_MAX;
                  w_state_nx = S_DECAY;
               end else begin
                  w_env_nx = r_env + c_ENV_ONE;
               end
            end
         end
         S_DECAY: begin
            if (!gate) begin
               w_state_nx = S_RELEASE;
            end else if (w_restart_req) begin
               w_restart  = 1'b1;
               w_state_nx = S_ATTACK;
               w_env_nx   = legato ? r_env : '0;
            end else if (w_tick) begin
               if ((w_rate != '0) && (w_env_x > w_sus_p1)) begin
                  w_env_nx = r_env - c_ENV_ONE;
               end else if (loop_en) begin
                  // Looping: next attack starts from sustain (legato) or 0.
                  w_state_nx = S_ATTACK;
                  w_env_nx   = legato ? sustain_level : '0;
               end else begin
                  w_state_nx = S_SUSTAIN;
                  w_env_nx   = sustain_level;
               end
            end
         end
         S_SUSTAIN: begin
            if (!gate) begin
               w_state_nx = S_RELEASE;
            end else if (w_restart_req) begin
               w_restart  = 1'b1;
               w_state_nx = S_ATTACK;
               w_env_nx   = legato ? r_env : '0;
            end else begin
               w_env_nx = sustain_level;
            end
         end
         S_RELEASE: begin
            if (w_rise || (retrig && gate)) begin
               w_restart  = 1'b1;
               w_state_nx = S_ATTACK;
               w_env_nx   = legato ? r_env : '0;
            end else if (w_tick) begin
               if ((w_rate == '0) || (r_env <= c_ENV_ONE)) begin
                  w_env_nx   = '0;
                  w_state_nx = S_IDLE;
                  w_done_nx  = 1'b1;
               end else begin
                  w_env_nx = r_env - c_ENV_ONE;
               end
            end
         end
         default: begin
            // Unreachable encodings recover to a silent idle.
            w_state_nx = S_IDLE;
            w_env_nx   = '0;
         end
      endcase
   end

   // Envelope FSM, rate counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_env          <= '0;
         r_cnt          <= '0;
         r_gate_prev    <= 1'b0;
         r_active       <= 1'b0;
         r_release_done <= 1'b0;
      end else begin
         r_state        <= w_state_nx;
         r_env          <= w_env_nx;
         r_cnt          <= w_reload ? w_load : (r_cnt - c_CNT_ONE);
         r_gate_prev    <= gate;
         r_active       <= (w_state_nx != S_IDLE);
         r_release_done <= w_done_nx;
      end
   end

   assign envelope_out = r_env;
   assign state_out    = r_state;
   assign active       = r_active;
   assign release_done = r_release_done;

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_adsr_envelope_gen
// Description : Scoreboard bench for adsr_envelope_gen. Directed scenarios
//               and random stimulus drive both the DUT and a behavioural
//               envelope model; a monitor compares every output cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adsr_envelope_gen;

   localparam int ENV_W      = 8;
   localparam int RATE_W     = 4;
   localparam int PRESCALE_W = 1;
   localparam int ENV_MAX    = (1 << ENV_W) - 1;

   localparam int IDLE = 0, ATTACK = 1, DECAY = 2, SUSTAIN = 3, RELEASE = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              gate, retrig, legato, loop_en;
   logic [RATE_W-1:0] attack_rate, decay_rate, release_rate;
   logic [ENV_W-1:0]  sustain_level;
   logic [ENV_W-1:0]  envelope_out;
   logic [2:0]        state_out;
   logic              active, release_done;

   typedef struct packed {
      logic [2:0]       st;
      logic [ENV_W-1:0] env;
      logic             act;
      logic             done;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0, failures = 0, done_cnt = 0, peak = 0;

   // behavioural model state: phase, level, clocks elapsed in current step
   int m_phase, m_level, m_elapsed, m_period;
   bit m_gate_seen, m_done;

   adsr_envelope_gen #(.ENV_W(ENV_W), .RATE_W(RATE_W), .PRESCALE_W(PRESCALE_W)) dut (
      .clk(clk), .rst_n(rst_n), .gate(gate), .retrig(retrig), .legato(legato),
      .loop_en(loop_en), .attack_rate(attack_rate), .decay_rate(decay_rate),
      .sustain_level(sustain_level), .release_rate(release_rate),
      .envelope_out(envelope_out), .state_out(state_out), .active(active),
      .release_done(release_done));

   always #5 clk = ~clk;

   function automatic int rate_of(input int ph);
      if (ph == ATTACK)  return int'(attack_rate);
      if (ph == DECAY)   return int'(decay_rate);
      if (ph == RELEASE) return int'(release_rate);
      return 0;
   endfunction

   task automatic model_reset();
      m_phase = IDLE; m_level = 0; m_elapsed = 0; m_period = 0;
      m_gate_seen = 1'b0; m_done = 1'b0;
   endtask

   // One clock of the envelope rules, using the inputs present at the edge.
   task automatic model_step();
      int  rate, sus, nph, nlev;
      bit  rise, restart, tick;
      rate    = rate_of(m_phase);
      sus     = int'(sustain_level);
      rise    = gate && !m_gate_seen;
      tick    = (rate == 0) || (m_elapsed + 1 >= m_period);
      nph     = m_phase;
      nlev    = m_level;
      restart = 1'b0;
      m_done  = 1'b0;
      if (m_phase == IDLE) begin
         nlev = 0;
         if (gate) nph = ATTACK;
      end else if (m_phase == RELEASE) begin
         if (rise || (retrig && gate)) begin
            nph = ATTACK; nlev = legato ? m_level : 0;
         end else if (tick) begin
            if (rate == 0 || m_level <= 1) begin
               nlev = 0; nph = IDLE; m_done = 1'b1;
            end else nlev = m_level - 1;
         end
      end else if (m_phase >= ATTACK && m_phase <= SUSTAIN) begin
         if (!gate) nph = RELEASE;
         else if (retrig || rise) begin
            restart = 1'b1; nph = ATTACK; nlev = legato ? m_level : 0;
         end else if (m_phase == ATTACK) begin
            if (tick) begin
               nlev = (rate == 0) ? ENV_MAX : ((m_level + 1 > ENV_MAX) ? ENV_MAX : m_level + 1);
               if (nlev == ENV_MAX) nph = DECAY;
            end
         end else if (m_phase == DECAY) begin
            if (tick) begin
               if (rate != 0 && m_level > sus + 1) nlev = m_level - 1;
               else if (loop_en) begin nph = ATTACK; nlev = legato ? sus : 0; end
               else begin nph = SUSTAIN; nlev = sus; end
            end
         end else nlev = sus;
      end
      if (nph != m_phase || restart || tick) begin
         m_elapsed = 0;
         m_period  = rate_of(nph) * (1 << PRESCALE_W);
      end else m_elapsed++;
      m_gate_seen = gate;
      m_phase     = nph;
      m_level     = nlev;
   endtask

   task automatic step();
      obs_t e;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      e.st   = 3'(m_phase);
      e.env  = ENV_W'(m_level);
      e.act  = (m_phase != IDLE);
      e.done = m_done;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Monitor: every output cycle is checked against the queued prediction.
   always @(negedge clk) begin
      obs_t a, e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.st = state_out; a.env = envelope_out; a.act = active; a.done = release_done;
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL cycle_compare t=%0t got state=%0d env=%0h act=%0b done=%0b want state=%0d env=%0h act=%0b done=%0b",
                     $time, a.st, a.env, a.act, a.done, e.st, e.env, e.act, e.done);
         end
         if (release_done) done_cnt++;
         if (int'(envelope_out) > peak) peak = int'(envelope_out);
      end
   end

   task automatic check(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s actual=%0d want=%0d", name, act, want);
      end
   endtask

   function automatic bit hit(input int kind, input int val);
      if (kind == 0) return int'(state_out) == val;
      if (kind == 1) return int'(envelope_out) >= val;
      return int'(envelope_out) <= val;
   endfunction

   // Run until a DUT condition holds; an expired budget counts as a failure.
   task automatic wait_for(input int kind, input int val, input int budget, input string name);
      int n = 0;
      while (!hit(kind, val) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (!hit(kind, val)) begin
         failures++;
         $display("FAIL %s timeout state=%0d env=%0h want kind=%0d val=%0h", name, state_out, envelope_out, kind, val);
      end
   endtask

   task automatic reset_pulse();
      settle();
      rst_n = 1'b0;
      #1;
      check("async_rst_state", int'(state_out), 0);
      check("async_rst_env", int'(envelope_out), 0);
      check("async_rst_active", int'(active), 0);
      check("async_rst_done", int'(release_done), 0);
      model_reset();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic set_rates(input int a, input int d, input int r);
      attack_rate = RATE_W'(a); decay_rate = RATE_W'(d); release_rate = RATE_W'(r);
   endtask

   task automatic go_idle();
      gate = 1'b0; retrig = 1'b0;
      wait_for(0, IDLE, 4000, "go_idle");
   endtask

   initial begin
      int lvl, loops, prev;
      rst_n = 1'b0; gate = 1'b0; retrig = 1'b0; legato = 1'b0; loop_en = 1'b0;
      set_rates(1, 1, 1);
      sustain_level = 8'h80;
      model_reset();
      step(); step();
      check("reset_state", int'(state_out), 0);
      check("reset_env", int'(envelope_out), 0);
      check("reset_active", int'(active), 0);
      check("reset_done", int'(release_done), 0);
      rst_n = 1'b1;
      step(); step();

      // full ADSR at rate 1
      peak = 0; done_cnt = 0;
      gate = 1'b1;
      wait_for(0, SUSTAIN, 2000, "adsr_reach_sustain");
      repeat (6) step();
      check("adsr_sustain_env", int'(envelope_out), 'h80);
      go_idle();
      repeat (2) step();
      settle();
      check("adsr_peak", peak, ENV_MAX);
      check("adsr_done_pulses", done_cnt, 1);
      check("adsr_active_end", int'(active), 0);

      // all rates instant
      set_rates(0, 0, 0);
      peak = 0; done_cnt = 0;
      gate = 1'b1;
      repeat (3) step();
      check("instant_state", int'(state_out), SUSTAIN);
      check("instant_env", int'(envelope_out), 'h80);
      gate = 1'b0;
      repeat (3) step();
      settle();
      check("instant_peak", peak, ENV_MAX);
      check("instant_done_pulses", done_cnt, 1);
      check("instant_idle", int'(state_out), IDLE);

      // re-gate during release, legato off then on
      set_rates(1, 1, 1);
      for (int lg = 0; lg < 2; lg++) begin
         legato = lg[0];
         gate = 1'b1;
         wait_for(1, 'h40, 2000, "regate_climb");
         gate = 1'b0;
         wait_for(2, 'h20, 2000, "regate_release");
         lvl = int'(envelope_out);
         gate = 1'b1;
         step();
         check("regate_state", int'(state_out), ATTACK);
         check("regate_env", int'(envelope_out), lg ? lvl : 0);
         repeat (8) step();
         go_idle();
      end

      // looping AD
      legato = 1'b1; loop_en = 1'b1; sustain_level = 8'h10;
      gate = 1'b1; loops = 0; prev = int'(state_out);
      for (int n = 0; n < 6000 && loops < 3; n++) begin
         step();
         if (prev == DECAY && int'(state_out) == ATTACK) loops++;
         prev = int'(state_out);
      end
      check("loop_cycles", loops, 3);
      wait_for(0, DECAY, 2000, "loop_reach_decay");
      step(); step();
      gate = 1'b0;
      step();
      check("loop_release", int'(state_out), RELEASE);
      go_idle();
      loop_en = 1'b0; legato = 1'b0;

      // sustain tracking and sustain raised during decay
      set_rates(0, 0, 0); sustain_level = 8'h80;
      gate = 1'b1;
      wait_for(0, SUSTAIN, 20, "sus_reach");
      sustain_level = 8'hA0;
      step();
      check("sus_follow", int'(envelope_out), 'hA0);
      go_idle();
      set_rates(0, 2, 0); sustain_level = 8'h40;
      gate = 1'b1;
      wait_for(0, DECAY, 20, "raise_decay");
      wait_for(2, 'h90, 2000, "raise_level");
      sustain_level = 8'hC0;
      wait_for(0, SUSTAIN, 20, "raise_sustain");
      check("raise_env", int'(envelope_out), 'hC0);
      go_idle();

      // reset mid-decay, then retrig with gate low during release
      set_rates(1, 1, 1); sustain_level = 8'h10;
      gate = 1'b1;
      wait_for(0, DECAY, 2000, "rst_decay");
      wait_for(2, 'h7F, 2000, "rst_level");
      reset_pulse();
      gate = 1'b0;
      step();
      gate = 1'b1;
      wait_for(1, 'h20, 2000, "rt_climb");
      gate = 1'b0;
      repeat (3) step();
      retrig = 1'b1;
      step();
      retrig = 1'b0;
      check("retrig_gate_low", int'(state_out), RELEASE);
      go_idle();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) gate = ~gate;
         retrig = ($urandom_range(24) == 0);
         if ($urandom_range(149) == 0) begin
            legato = 1'($urandom); loop_en = 1'($urandom);
         end
         if ($urandom_range(79) == 0)
            set_rates($urandom_range(3), $urandom_range(3), $urandom_range(3));
         if ($urandom_range(59) == 0) sustain_level = ENV_W'($urandom_range(ENV_MAX));
         if (i % 1500 == 1499) reset_pulse();
         else step();
      end
      retrig = 1'b0;
      settle();
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
